// File: rtl/rf_write_queue_pkg.sv
// Shared types for the register file write-back queue.
// Register count, address width and the queue entry record.
package rf_write_queue_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    // Widest register data an entry can carry
    localparam int RF_MAX_W = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t             addr;
        logic [RF_MAX_W-1:0]   data;
    } wq_entry_t;

endpackage

// File: rtl/wq_fifo.sv
// Write-back queue storage: ring buffer with count-based full/empty
// and a newest-entry address lookup for two read ports.
module wq_fifo
    import rf_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  wq_entry_t           push_entry,
    input  logic                hold,
    output logic                not_full,
    output logic                pop,
    output wq_entry_t           head_entry,
    output logic [3:0]          count,
    input  reg_addr_t           look1_addr,
    input  reg_addr_t           look2_addr,
    output logic                look1_hit,
    output logic                look2_hit,
    output logic [RF_MAX_W-1:0] look1_data,
    output logic [RF_MAX_W-1:0] look2_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wq_entry_t        mem_q [DEPTH];
    wq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [3:0]       count_q, count_d;
    logic [PTR_W-1:0] idx;

    assign not_full   = count_q < 4'(DEPTH);
    assign pop        = (count_q != 4'd0) && !hold;
    assign head_entry = mem_q[head_q];
    assign count      = count_q;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push && not_full) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        unique case ({push && not_full, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to newest so the newest matching entry wins
    always_comb begin
        look1_hit  = 1'b0;
        look2_hit  = 1'b0;
        look1_data = '0;
        look2_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (4'(i) < count_q) begin
                if (mem_q[idx].addr == look1_addr) begin
                    look1_hit  = 1'b1;
                    look1_data = mem_q[idx].data;
                end
                if (mem_q[idx].addr == look2_addr) begin
                    look2_hit  = 1'b1;
                    look2_data = mem_q[idx].data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// Register file fronted by a write-back queue; reads bypass from
// the newest queued write, else the array; x0 is hardwired zero.
module rf_write_queue
    import rf_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hold,
    input  logic [4:0]       Src1addr,
    input  logic [4:0]       Src2addr,
    output logic [WIDTH-1:0] Src1,
    output logic [WIDTH-1:0] Src2,
    output logic [3:0]       q_count,
    output logic             busy
);

    logic [WIDTH-1:0]    rf_q [NUM_REGS];
    logic [WIDTH-1:0]    rf_d [NUM_REGS];
    logic                push;
    logic                pop;
    wq_entry_t           push_entry;
    wq_entry_t           head_entry;
    logic                look1_hit, look2_hit;
    logic [RF_MAX_W-1:0] look1_data, look2_data;

    // Writes to x0 complete the handshake but are dropped here
    assign push            = wr_valid && wr_ready && (wr_addr != '0);
    assign push_entry.addr = wr_addr;
    assign push_entry.data = RF_MAX_W'(wr_data);
    assign busy            = q_count != 4'd0;

    wq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .hold       (hold),
        .not_full   (wr_ready),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (q_count),
        .look1_addr (Src1addr),
        .look2_addr (Src2addr),
        .look1_hit  (look1_hit),
        .look2_hit  (look2_hit),
        .look1_data (look1_data),
        .look2_data (look2_data)
    );

    always_comb begin
        rf_d = rf_q;
        if (pop) begin
            rf_d[head_entry.addr] = WIDTH'(head_entry.data);
        end
        rf_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    always_comb begin
        Src1 = rf_q[Src1addr];
        if (look1_hit) begin
            Src1 = WIDTH'(look1_data);
        end
        if (Src1addr == '0) begin
            Src1 = '0;
        end
        Src2 = rf_q[Src2addr];
        if (look2_hit) begin
            Src2 = WIDTH'(look2_data);
        end
        if (Src2addr == '0) begin
            Src2 = '0;
        end
    end

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: a reference queue/array
// model acts as scoreboard, popped as the DUT drains.
module tb_rf_write_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        hold;
    logic [4:0]  Src1addr;
    logic [4:0]  Src2addr;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic [3:0]  q_count;
    logic        busy;

    ent_t        mq[$];
    logic [31:0] marr [32];
    int          n_tests;
    int          n_fail;

    rf_write_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hold     (hold),
        .Src1addr (Src1addr),
        .Src2addr (Src2addr),
        .Src1     (Src1),
        .Src2     (Src2),
        .q_count  (q_count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr == a) return mq[i].data;
        end
        return marr[a];
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) marr[i] = 32'd0;
    endtask

    // One clock edge; the model decides accept/drain from pre-edge state
    task automatic step(input string tag);
        logic acc;
        logic drn;
        ent_t e;
        acc = wr_valid && (mq.size() < DEPTH);
        drn = (mq.size() > 0) && !hold;
        chk({tag, ".rdy_pre"}, 32'(wr_ready), 32'(mq.size() < DEPTH));
        @(posedge clk);
        if (drn) begin
            e = mq.pop_front();
            marr[e.addr] = e.data;
        end
        if (acc && wr_addr != 5'd0) begin
            e.addr = wr_addr;
            e.data = wr_data;
            mq.push_back(e);
        end
        #1;
        chk({tag, ".cnt"}, 32'(q_count), 32'(mq.size()));
        chk({tag, ".busy"}, 32'(busy), 32'(mq.size() != 0));
    endtask

    task automatic push(input string tag, input logic [4:0] a,
                        input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step(tag);
        wr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a1,
                          input logic [4:0] a2);
        Src1addr = a1;
        Src2addr = a2;
        #1;
        chk({tag, ".src1"}, Src1, mread(a1));
        chk({tag, ".src2"}, Src2, mread(a2));
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        hold     = 1'b0;
        Src1addr = '0;
        Src2addr = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst.cnt", 32'(q_count), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rdy", 32'(wr_ready), 32'd1);
        rd_chk("rst.rd", 5'd5, 5'd31);
        rst_n = 1'b1;
        step("idle");

        // Held push is visible through bypass, then drains to the array
        hold = 1'b1;
        push("t33.push", 5'd5, 32'h0000_00AA);
        rd_chk("t33.byp", 5'd5, 5'd6);
        chk("t33.abs", Src1, 32'h0000_00AA);
        hold = 1'b0;
        step("t33.drn");
        rd_chk("t33.arr", 5'd5, 5'd5);
        chk("t33.abs2", Src1, 32'h0000_00AA);

        // Fill to DEPTH under hold, refuse one more, then drain in order
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push("t34.fill", 5'(i), 32'(i * 32'h11));
        end
        chk("t34.full", 32'(wr_ready), 32'd0);
        push("t34.extra", 5'd9, 32'h55);
        chk("t34.still_full", 32'(q_count), 32'd4);
        rd_chk("t34.rd", 5'd4, 5'd9);
        hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step("t34.drn");
            rd_chk("t34.rd_drn", 5'(i), 5'd9);
        end

        // Two queued writes to one register: newest wins, array ends newest
        hold = 1'b1;
        push("t35.a", 5'd7, 32'h1);
        push("t35.b", 5'd7, 32'h2);
        rd_chk("t35.byp", 5'd3, 5'd7);
        chk("t35.abs", Src2, 32'h2);
        hold = 1'b0;
        step("t35.d1");
        rd_chk("t35.mid", 5'd7, 5'd7);
        step("t35.d2");
        rd_chk("t35.end", 5'd7, 5'd7);
        chk("t35.abs_end", Src1, 32'h2);

        // x0 write is accepted but never queued
        push("t36.x0", 5'd0, 32'hFFFF_FFFF);
        rd_chk("t36.rd", 5'd0, 5'd0);

        // Pending input data is not bypassed before the edge
        hold = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'hDEAD_BEEF;
        rd_chk("t25.nobyp", 5'd5, 5'd5);
        step("t25.push");
        wr_valid = 1'b0;
        rd_chk("t25.byp", 5'd5, 5'd5);
        hold = 1'b0;
        step("t25.drn");

        // Steady state at two entries with concurrent push and drain
        hold = 1'b1;
        push("t37.p0", 5'd10, $urandom);
        push("t37.p1", 5'd11, $urandom);
        hold = 1'b0;
        push("t37.s0", 5'd12, $urandom);
        push("t37.s1", 5'd13, $urandom);
        push("t37.s2", 5'd12, $urandom);
        push("t37.s3", 5'd14, $urandom);
        push("t37.s4", 5'd15, $urandom);
        chk("t37.cnt2", 32'(q_count), 32'd2);
        step("t37.d0");
        step("t37.d1");
        rd_chk("t37.rdA", 5'd10, 5'd11);
        rd_chk("t37.rdB", 5'd12, 5'd13);
        rd_chk("t37.rdC", 5'd14, 5'd15);

        // Reset with three queued entries discards them
        hold = 1'b1;
        push("t38.p0", 5'd20, 32'h2020);
        push("t38.p1", 5'd21, 32'h2121);
        push("t38.p2", 5'd22, 32'h2222);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t38.cnt", 32'(q_count), 32'd0);
        chk("t38.busy", 32'(busy), 32'd0);
        chk("t38.rdy", 32'(wr_ready), 32'd1);
        rd_chk("t38.rdA", 5'd20, 5'd22);
        rd_chk("t38.rdB", 5'd5, 5'd7);
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;
        rd_chk("t38.rdC", 5'd12, 5'd10);
        push("t38.after", 5'd3, 32'h3333);
        step("t38.drn");
        rd_chk("t38.rdD", 5'd3, 5'd21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_queue.md
RF_WRITE_QUEUE -- requirements
Module: rf_write_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of write-queue entries (power of two, 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the register data width.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port wr_valid  input  1  the producer offers a write-back of wr_data to wr_addr.
REQ-006 Port wr_ready  output  1  the queue can accept a write this cycle.
REQ-007 Port wr_addr  input  5  destination register number (the rd field).
REQ-008 Port wr_data  input  WIDTH  ALU result to write back.
REQ-009 Port hold  input  1  when high, the queue does not drain into the register array.
REQ-010 Port Src1addr  input  5  read port 1 register number.
REQ-011 Port Src2addr  input  5  read port 2 register number.
REQ-012 Port Src1  output  WIDTH  read port 1 data, combinational.
REQ-013 Port Src2  output  WIDTH  read port 2 data, combinational.
REQ-014 Port q_count  output  4  number of occupied queue entries, 0..DEPTH.
REQ-015 Port busy  output  1  high when q_count is non-zero.

Function
REQ-016 The block SHALL contain a 32 x WIDTH register array; register 0 SHALL always read as zero.
REQ-017 wr_ready SHALL be high exactly when q_count < DEPTH; it SHALL NOT depend combinationally on wr_valid or on a same-cycle drain.
REQ-018 A push SHALL occur on a rising edge where wr_valid and wr_ready are both high; the entry {wr_addr, wr_data} is appended at the tail.
REQ-019 A handshake with wr_addr = 0 SHALL complete (accepted) but SHALL NOT enqueue an entry or change q_count.
REQ-020 A drain SHALL occur on a rising edge where q_count > 0 and hold is low: the head entry is written to the register array and removed, one entry per cycle maximum.
REQ-021 Latency: data accepted at edge N SHALL be visible on Src1/Src2 from after edge N (via bypass), and in the register array no earlier than edge N+1.
REQ-022 Simultaneous push and drain SHALL leave q_count unchanged; FIFO order SHALL be preserved.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from q_count, not pointer equality.
REQ-024 Read data SHALL be: zero when the address is 0; otherwise wr_data of the newest queue entry whose address matches; otherwise the register array content.
REQ-025 The current cycle's wr_data on the input SHALL NOT be bypassed to Src1/Src2 before it is pushed.
REQ-026 Two queued entries with the same address SHALL drain in order, so the array ends holding the newer value.
REQ-027 hold high with q_count = DEPTH SHALL keep wr_ready low; no entry is lost or overwritten.

Reset
REQ-028 While rst_n is low, all 32 registers SHALL be zero, the queue SHALL be empty, q_count = 0, busy = 0, wr_ready = 1.
REQ-029 Reset asserted mid-operation SHALL discard all pending queue entries without writing them to the array.
REQ-030 The first push or drain SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold the register-count constant (32), the address width (5) and the queue entry record {addr, data}.
REQ-032 The queue SHALL be a sub-module named wq_fifo (storage, pointers, count, newest-match lookup); rf_write_queue SHALL hold the array and the read muxing.

Verification
REQ-033 Reset, then push addr 5 = 0x0000_00AA with hold high -> Src1addr=5 reads 0xAA immediately after the edge; q_count = 1; after hold falls and one edge, q_count = 0 and Src1 still 0xAA.
REQ-034 hold high, push 4 entries (addr 1..4, data 0x11..0x44) -> wr_ready low after the 4th edge, q_count = 4; a 5th wr_valid is not accepted; release hold -> 4 drains in 4 edges, order 1..4.
REQ-035 hold high, push addr 7 = 0x1 then addr 7 = 0x2 -> Src2addr=7 reads 0x2; after full drain the array holds 0x2.
REQ-036 Push addr 0 = 0xFFFF_FFFF -> handshake completes, q_count unchanged, Src1addr=0 reads 0.
REQ-037 Queue at q_count = 2, hold low, push each cycle for 5 cycles -> q_count stays 2 throughout; all values appear in the array in push order.
REQ-038 Queue holding 3 entries, pulse rst_n low between edges -> q_count = 0 at once; all registers read 0 afterwards.
